// File: rtl/button_emulator_pkg.sv
// Shared types and constants for the button press emulator.
package button_emulator_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRESS_HI,
      S_PRESS_LO,
      S_HOLD,
      S_REL_LO,
      S_REL_HI,
      S_FINISH
   } state_t;

   localparam int unsigned LFSR_W    = 16;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Feedback taps 16,14,13,11 expressed as a bit mask over q[15:0].
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used as the bounce jitter source.
module lfsr16
   import button_emulator_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   output logic [LFSR_W-1:0] q
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) q <= LFSR_SEED;
      else        q <= {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
   end

endmodule

// File: rtl/button_emulator.sv
// Emulates one bouncy mechanical button press: press bounce, hold, release bounce.
module button_emulator
   import button_emulator_pkg::*;
#(
   parameter int unsigned CNT_W = 16,
   parameter int unsigned LEN_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] hold_cycles,
   input  logic [3:0]       bounce_count,
   input  logic [LEN_W-1:0] bounce_len,
   input  logic [LEN_W-1:0] jitter_mask,
   output logic             button,
   output logic             busy,
   output logic             done,
   output logic [7:0]       press_count
);

   localparam int unsigned PH_W = LEN_W + 1;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cfg_hold, hold_cnt, hold_cnt_nxt, hold_src, hold_load;
   logic [3:0]       cfg_bc, pair_cnt, pair_cnt_nxt, bc_src;
   logic [LEN_W-1:0] cfg_len, cfg_mask, len_src, mask_src;
   logic [PH_W-1:0]  phase_cnt, phase_cnt_nxt, half_len, half_load;
   logic [LFSR_W-1:0] lfsr_q;
   logic             accept;
   logic             button_nxt, busy_nxt, done_nxt;
   logic             unused_lfsr;

   lfsr16 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .q     (lfsr_q)
   );

   assign unused_lfsr = ^lfsr_q[LFSR_W-1:LEN_W];

   // In IDLE the first phase length is taken from the live inputs, later from the latched copy.
   assign accept   = (state == S_IDLE) && start && !abort;
   assign len_src  = (state == S_IDLE) ? bounce_len   : cfg_len;
   assign mask_src = (state == S_IDLE) ? jitter_mask  : cfg_mask;
   assign hold_src = (state == S_IDLE) ? hold_cycles  : cfg_hold;
   assign bc_src   = (state == S_IDLE) ? bounce_count : cfg_bc;

   always_comb begin
      half_len = PH_W'(len_src) + PH_W'(lfsr_q[LEN_W-1:0] & mask_src);
      if (half_len == '0) half_len = PH_W'(1);
      half_load = half_len - PH_W'(1);
      hold_load = (hold_src == '0) ? '0 : hold_src - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      phase_cnt_nxt = phase_cnt;
      hold_cnt_nxt  = hold_cnt;
      pair_cnt_nxt  = pair_cnt;
      if (abort && (state != S_IDLE)) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (accept) begin
               pair_cnt_nxt = bc_src;
               if (bc_src == '0) begin
                  state_nxt    = S_HOLD;
                  hold_cnt_nxt = hold_load;
               end else begin
                  state_nxt     = S_PRESS_HI;
                  phase_cnt_nxt = half_load;
               end
            end
            S_PRESS_HI, S_REL_LO: begin
               if (phase_cnt == '0) begin
                  state_nxt     = (state == S_PRESS_HI) ? S_PRESS_LO : S_REL_HI;
                  phase_cnt_nxt = half_load;
               end else begin
                  phase_cnt_nxt = phase_cnt - PH_W'(1);
               end
            end
            S_PRESS_LO: begin
               if (phase_cnt != '0) begin
                  phase_cnt_nxt = phase_cnt - PH_W'(1);
               end else if (pair_cnt <= 4'd1) begin
                  state_nxt    = S_HOLD;
                  hold_cnt_nxt = hold_load;
                  pair_cnt_nxt = cfg_bc;
               end else begin
                  state_nxt     = S_PRESS_HI;
                  phase_cnt_nxt = half_load;
                  pair_cnt_nxt  = pair_cnt - 4'd1;
               end
            end
            S_HOLD: begin
               if (hold_cnt != '0) begin
                  hold_cnt_nxt = hold_cnt - CNT_W'(1);
               end else if (cfg_bc == '0) begin
                  state_nxt = S_FINISH;
               end else begin
                  state_nxt     = S_REL_LO;
                  phase_cnt_nxt = half_load;
               end
            end
            S_REL_HI: begin
               if (phase_cnt != '0) begin
                  phase_cnt_nxt = phase_cnt - PH_W'(1);
               end else if (pair_cnt <= 4'd1) begin
                  state_nxt = S_FINISH;
               end else begin
                  state_nxt     = S_REL_LO;
                  phase_cnt_nxt = half_load;
                  pair_cnt_nxt  = pair_cnt - 4'd1;
               end
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next state so they are registered without extra latency.
   always_comb begin
      button_nxt = 1'b0;
      busy_nxt   = 1'b0;
      done_nxt   = 1'b0;
      if (state_nxt != S_IDLE) busy_nxt = 1'b1;
      case (state_nxt)
         S_PRESS_HI, S_HOLD, S_REL_HI: button_nxt = 1'b1;
         S_FINISH:                     done_nxt   = 1'b1;
         default:                      ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         button      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         press_count <= '0;
         phase_cnt   <= '0;
         hold_cnt    <= '0;
         pair_cnt    <= '0;
         cfg_hold    <= '0;
         cfg_bc      <= '0;
         cfg_len     <= '0;
         cfg_mask    <= '0;
      end else begin
         button    <= button_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         phase_cnt <= phase_cnt_nxt;
         hold_cnt  <= hold_cnt_nxt;
         pair_cnt  <= pair_cnt_nxt;
         if (done_nxt) press_count <= press_count + 8'd1;
         if (accept) begin
            cfg_hold <= hold_cycles;
            cfg_bc   <= bounce_count;
            cfg_len  <= bounce_len;
            cfg_mask <= jitter_mask;
         end
      end
   end

endmodule

// File: tb/tb_button_emulator.sv
// Directed self-checking bench for button_emulator: records button run lengths per press.
module tb_button_emulator;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [15:0] hold_cycles;
   logic [3:0]  bounce_count;
   logic [7:0]  bounce_len;
   logic [7:0]  jitter_mask;
   logic        button;
   logic        busy;
   logic        done;
   logic [7:0]  press_count;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_count;

   bit          lvl_q[$];
   int          len_q[$];
   logic [15:0] pre_q[$];
   int          done_cnt;
   int          cyc;
   logic [15:0] ref_lfsr;

   int exp_len32 [10] = '{250, 250, 250, 250, 21000, 250, 250, 250, 250, 2};

   button_emulator dut (
      .clk          (clk),
      .reset        (rst_n),
      .start        (start),
      .abort        (abort),
      .hold_cycles  (hold_cycles),
      .bounce_count (bounce_count),
      .bounce_len   (bounce_len),
      .jitter_mask  (jitter_mask),
      .button       (button),
      .busy         (busy),
      .done         (done),
      .press_count  (press_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference jitter source: taps 16,14,13,11 from seed ACE1.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ref_lfsr <= 16'hACE1;
      else        ref_lfsr <= {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Pulse start, then record (level, length, lfsr-before-edge) of every button run until busy drops.
   task automatic do_press(input int budget, input int poke_cyc, input logic [15:0] poke_hold,
                           input int abort_cyc, input bit start_at_done);
      int          len;
      bit          cur;
      logic [15:0] pre;
      lvl_q.delete();
      len_q.delete();
      pre_q.delete();
      done_cnt = 0;
      cyc      = 0;
      pre      = ref_lfsr;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cur   = button;
      len   = 1;
      lvl_q.push_back(cur);
      pre_q.push_back(pre);
      if (done) done_cnt++;
      while (busy && cyc < budget) begin
         if (cyc == poke_cyc) begin
            start       = 1'b1;
            hold_cycles = poke_hold;
         end
         if (cyc == abort_cyc) abort = 1'b1;
         if (start_at_done && done) start = 1'b1;
         pre = ref_lfsr;
         @(posedge clk); #1;
         start = 1'b0;
         abort = 1'b0;
         cyc++;
         if (done) done_cnt++;
         if (button == cur) begin
            len++;
         end else begin
            len_q.push_back(len);
            cur = button;
            len = 1;
            lvl_q.push_back(cur);
            pre_q.push_back(pre);
         end
      end
      len_q.push_back(len);
      check_eq("press_bounded", 32'(busy), 32'd0);
   endtask

   task automatic check_jitter_press();
      int exp_l;
      check_eq("jit_runs", 32'(len_q.size()), 32'd14);
      if (len_q.size() == 14) begin
         for (int i = 0; i < 13; i++) begin
            check_eq("jit_level", 32'(lvl_q[i]), 32'((i < 6) ? (i % 2 == 0) :
                                                  (i == 6) ? 1 : (i % 2 == 0)));
            if (i != 6) begin
               exp_l = 10 + int'(pre_q[i][7:0] & 8'h0F);
               check_eq("jit_len", 32'(len_q[i]), 32'(exp_l));
               check_eq("jit_range", 32'(len_q[i] >= 10 && len_q[i] <= 25), 32'd1);
            end
         end
         check_eq("jit_hold", 32'(len_q[6]), 32'd5);
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      start        = 1'b0;
      abort        = 1'b0;
      hold_cycles  = 16'd0;
      bounce_count = 4'd0;
      bounce_len   = 8'd0;
      jitter_mask  = 8'd0;
      exp_count    = 0;

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_button", 32'(button), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_count", 32'(press_count), 32'd0);

      // Plain hold press started on the first edge after reset release.
      rst_n       = 1'b1;
      hold_cycles = 16'd20000;
      do_press(30000, -1, 16'd0, -1, 1'b0);
      exp_count++;
      check_eq("hold_runs", 32'(len_q.size()), 32'd2);
      check_eq("hold_first_lvl", 32'(lvl_q[0]), 32'd1);
      check_eq("hold_len", 32'(len_q[0]), 32'd20000);
      check_eq("hold_tail", 32'(len_q[1]), 32'd2);
      check_eq("hold_done", 32'(done_cnt), 32'd1);
      check_eq("hold_count", 32'(press_count), 32'(exp_count));

      // Two bounce pairs with fixed length.
      bounce_count = 4'd2;
      bounce_len   = 8'd250;
      jitter_mask  = 8'd0;
      hold_cycles  = 16'd21000;
      do_press(30000, -1, 16'd0, -1, 1'b0);
      exp_count++;
      check_eq("bnc_runs", 32'(len_q.size()), 32'd10);
      if (len_q.size() == 10) begin
         for (int i = 0; i < 10; i++) begin
            check_eq("bnc_len", 32'(len_q[i]), 32'(exp_len32[i]));
            check_eq("bnc_lvl", 32'(lvl_q[i]), 32'((i % 2 == 0) ? 1 : 0));
         end
      end
      check_eq("bnc_done", 32'(done_cnt), 32'd1);
      check_eq("bnc_count", 32'(press_count), 32'(exp_count));

      // Jittered bounce, two runs started at different times.
      bounce_count = 4'd3;
      bounce_len   = 8'd10;
      jitter_mask  = 8'h0F;
      hold_cycles  = 16'd5;
      do_press(2000, -1, 16'd0, -1, 1'b0);
      check_jitter_press();
      repeat (13) @(posedge clk);
      #1;
      do_press(2000, -1, 16'd0, -1, 1'b0);
      check_jitter_press();
      exp_count += 2;
      check_eq("jit_count", 32'(press_count), 32'(exp_count));

      // Abort 100 cycles into HOLD.
      bounce_count = 4'd0;
      jitter_mask  = 8'd0;
      hold_cycles  = 16'd1000;
      do_press(2000, -1, 16'd0, 99, 1'b0);
      check_eq("abort_cycles", 32'(cyc), 32'd100);
      check_eq("abort_hold_len", 32'(len_q[0]), 32'd100);
      check_eq("abort_button", 32'(button), 32'd0);
      check_eq("abort_no_done", 32'(done_cnt), 32'd0);
      check_eq("abort_count", 32'(press_count), 32'(exp_count));

      // Start and abort together in IDLE do nothing.
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      check_eq("idle_abort_busy", 32'(busy), 32'd0);
      check_eq("idle_abort_button", 32'(button), 32'd0);

      // Restart after abort; extra start and hold change mid-press, start on FINISH.
      hold_cycles = 16'd50;
      do_press(500, 10, 16'd7, -1, 1'b1);
      exp_count++;
      check_eq("latch_runs", 32'(len_q.size()), 32'd2);
      check_eq("latch_len", 32'(len_q[0]), 32'd50);
      check_eq("latch_done", 32'(done_cnt), 32'd1);
      check_eq("latch_count", 32'(press_count), 32'(exp_count));
      @(posedge clk); #1;
      check_eq("finish_start_ignored", 32'(busy), 32'd0);

      // Reset mid-press drops the button asynchronously.
      hold_cycles = 16'd100;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check_eq("pre_reset_button", 32'(button), 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("async_button", 32'(button), 32'd0);
      check_eq("async_busy", 32'(busy), 32'd0);
      check_eq("async_count", 32'(press_count), 32'd0);
      @(posedge clk); #1;
      check_eq("reset_no_done", 32'(done), 32'd0);
      rst_n     = 1'b1;
      exp_count = 0;

      // 256 short presses wrap the counter.
      hold_cycles = 16'd1;
      for (int p = 0; p < 256; p++) begin
         do_press(20, -1, 16'd0, -1, 1'b0);
         exp_count = (exp_count + 1) % 256;
         if (p == 254) check_eq("count_255", 32'(press_count), 32'd255);
      end
      check_eq("count_wrap", 32'(press_count), 32'(exp_count));
      check_eq("wrap_len", 32'(len_q[0]), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/button_emulator.md
BUTTON_EMULATOR -- requirements
Module: button_emulator

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of hold counter and hold_cycles.
REQ-002 SHALL have parameter LEN_W, default 8, width of bounce phase counter and bounce_len.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request one emulated press; honoured only in IDLE.
REQ-006 SHALL have port abort  input  1  cancel the press in progress.
REQ-007 SHALL have port hold_cycles  input  CNT_W  stable-high duration, in cycles.
REQ-008 SHALL have port bounce_count  input  4  bounce pulse pairs per edge.
REQ-009 SHALL have port bounce_len  input  LEN_W  base length of each bounce half-phase, in cycles.
REQ-010 SHALL have port jitter_mask  input  LEN_W  mask on LFSR bits added to each bounce half-phase.
REQ-011 SHALL have port button  output  1  emulated raw button level, registered; feeds the debouncer button input.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a press completes normally.
REQ-014 SHALL have port press_count  output  8  completed presses, wraps 255->0.

Function
REQ-015 SHALL implement states IDLE, PRESS_HI, PRESS_LO, HOLD, REL_LO, REL_HI, FINISH.
REQ-016 SHALL latch hold_cycles, bounce_count, bounce_len and jitter_mask into internal registers when start is accepted; input changes while busy SHALL have no effect.
REQ-017 SHALL, on start accepted in IDLE, raise button on the next rising edge (1-cycle latency) and enter PRESS_HI, or HOLD if bounce_count=0.
REQ-018 SHALL define half-phase length L = max(1, bounce_len + (lfsr[LEN_W-1:0] & jitter_mask)), computed at LEN_W+1 bits with no truncation, resampled at entry to each half-phase.
REQ-019 SHALL, in press bounce, drive button=1 for L cycles (PRESS_HI) then button=0 for L cycles (PRESS_LO), repeated bounce_count times, then enter HOLD.
REQ-020 SHALL drive button=1 in HOLD for exactly max(1, hold_cycles) cycles.
REQ-021 SHALL, in release bounce, drive button=0 for L cycles (REL_LO) then button=1 for L cycles (REL_HI), repeated bounce_count times; with bounce_count=0, HOLD SHALL go directly to FINISH.
REQ-022 SHALL in FINISH drive button=0, pulse done for exactly one cycle, increment press_count, and return to IDLE on the next edge.
REQ-023 SHALL, on abort high in any non-IDLE state, go to IDLE on the next edge with button=0, no done pulse and no press_count increment; abort has priority over start and over every state transition.
REQ-024 SHALL ignore start while busy, including on the FINISH cycle; start and abort both high in IDLE SHALL leave the block in IDLE.
REQ-025 SHALL run a 16-bit Fibonacci LFSR, taps 16,14,13,11, advancing every cycle whether idle or busy.

Reset
REQ-026 SHALL, while reset=0, force state IDLE, button=0, busy=0, done=0, press_count=0, LFSR=16'hACE1, and clear all counters and latched configuration.
REQ-027 SHALL accept start on the first rising edge after reset deasserts.
REQ-028 SHALL, on reset asserted mid-press, drop button to 0 immediately (asynchronous), with no done pulse.

Structure
REQ-029 SHALL place the state enum, LFSR seed 16'hACE1 and tap constants in shared package button_emulator_pkg.
REQ-030 SHALL instantiate the LFSR as sub-module lfsr16 (clk, reset, q[15:0]).

Verification
REQ-031 Bench: hold_cycles=20000, bounce_count=0, jitter_mask=0, start pulse -> button high for exactly 20000 cycles starting 1 cycle after start; done pulse; press_count=1; downstream debouncer out_mode 1->2.
REQ-032 Bench: bounce_count=2, bounce_len=250, jitter_mask=0, hold_cycles=21000 -> button sequence 250 hi / 250 lo / 250 hi / 250 lo / 21000 hi / 250 lo / 250 hi / 250 lo / 250 hi / 0; debouncer advances exactly once.
REQ-033 Bench: bounce_count=3, bounce_len=10, jitter_mask=8'h0F -> every half-phase length in [10,25]; total press-bounce cycles vary between two runs with different start times.
REQ-034 Bench: abort asserted 100 cycles into HOLD -> button=0 and busy=0 next cycle, no done, press_count unchanged; a further start is accepted.
REQ-035 Bench: second start while busy, and hold_cycles changed mid-press -> ignored; press duration matches the latched value.
REQ-036 Bench: reset low mid-press, then 256 full presses -> button falls immediately on reset; press_count wraps 255->0.
